data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Responder side of the core's load/store port: a word-organised data RAM behind a
//  valid/ready request channel and a valid/ready response channel. It services one
//  RV32I load or store (LB/LH/LW/LBU/LHU/SB/SH/SW) at a time with a fixed access latency.
//  It sits between the core's ALU-address/rs2-data path and its write-back mux.
// PARAMETERS
//  DEPTH_WORDS  256  number of 32-bit words; power of 2, >= 4
//  LATENCY      2    cycles from request accept to first resp_valid; >= 1
// PORTS
//  clk         in   1   rising-edge clock
//  rst         in   1   asynchronous reset, active-high
//  req_valid   in   1   request present
//  req_ready   out  1   responder can accept a request
//  req_we      in   1   1 = store, 0 = load
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data; low byte/half used for SB/SH
//  req_func3   in   3   RV32I funct3: size and sign of the access
//  resp_valid  out  1   response present
//  resp_ready  in   1   core accepts response
//  resp_rdata  out  32  load data, extended to 32 bits; 0 for stores and errors
//  resp_err    out  1   access rejected (misaligned, out of range, illegal func3)
// BEHAVIOUR
//  Reset (async, rst=1): state IDLE, LATENCY counter 0, resp_valid=0, resp_rdata=0,
//   resp_err=0, req_ready=0 while rst is high. RAM contents are not reset.
//  FSM: IDLE -> WAIT -> RESP -> IDLE.
//   IDLE: req_ready=1. On req_valid&&req_ready, latch we/addr/wdata/func3. Go to RESP if
//    LATENCY=1, else WAIT with count=LATENCY-1.
//   WAIT: req_ready=0; decrement each cycle; go to RESP when count reaches 1.
//   On entry to RESP (same edge): compute error; perform store, or register load data.
//    resp_valid=1 is therefore visible exactly LATENCY cycles after the accept edge.
//   RESP: resp_valid, resp_rdata, resp_err held stable until resp_valid&&resp_ready.
//    Then go to IDLE. No new request is accepted in the handshake cycle, so the minimum
//    request-to-request spacing is LATENCY+1 cycles.
//  Decode by func3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU (loads); 000 SB, 001 SH,
//   010 SW (stores). All other codes are errors.
//  Word index = addr[log2(DEPTH_WORDS)+1:2]. Out of range if addr[31:2] >= DEPTH_WORDS.
//  Alignment: H requires addr[0]=0; W requires addr[1:0]=00; B is always aligned.
//  Load lanes: byte = word[8*addr[1:0] +: 8], half = word[16*addr[1] +: 16].
//   LB/LH sign-extend; LBU/LHU zero-extend.
//  Store: byte enables write only the addressed lane(s). Other bytes keep their value.
//  Error: no RAM write, resp_rdata=0, resp_err=1. The response handshake is still
//   required.
//  req_valid dropping while the responder is not in IDLE is ignored; the request is
//   latched at accept.
//  Reset mid-operation: the transaction is aborted. A store not yet committed (still in
//   WAIT) is discarded. No response is issued after reset.
//  resp_ready held high in RESP: the response completes in its first RESP cycle.
// TESTING
//  1 SW addr=0x10 wdata=0xDEADBEEF, then LW 0x10 -> resp_rdata=0xDEADBEEF, err=0.
//    Check that resp_valid rises exactly LATENCY cycles after each accept.
//  2 SB 0x13 wdata=0x80, then LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080.
//    LW 0x10 -> 0x80ADBEEF.
//  3 SH 0x12 wdata=0x1234 -> LHU 0x12 = 0x1234. LH 0x11 -> err=1, rdata=0.
//    SW 0x16 -> err=1 and memory unchanged.
//  4 LW at 4*DEPTH_WORDS (0x400 for defaults) -> err=1. func3=011 -> err=1.
//  5 Hold resp_ready=0 for 5 cycles in RESP -> outputs stable and req_ready=0.
//    Then resp_ready=1 -> IDLE next cycle, and req_ready=1.
//  6 Assert rst during WAIT of SW 0x20 wdata=0x55 -> resp_valid=0. After reset, SW 0x20
//    wdata=0 then LW 0x20 -> 0x0. Separately, after reset without rewriting, LW 0x20
//    must not return 0x55.

Source files
------------

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - word-organised data RAM responder for RV32I loads/stores
// One transaction at a time: IDLE accepts, WAIT burns latency, RESP holds the result.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_func3,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int AW   = $clog2(DEPTH_WORDS);
    localparam int CW   = (LATENCY < 2) ? 1 : $clog2(LATENCY);
    localparam bit LAT1 = (LATENCY == 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_count;
    logic          r_we;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [2:0]    r_func3;
    logic [31:0]   r_rdata;
    logic          r_err;
    logic [31:0]   r_mem [DEPTH_WORDS];

    logic          w_accept;
    logic          w_enter_resp;
    logic          w_we;
    logic [31:0]   w_addr;
    logic [31:0]   w_wdata;
    logic [2:0]    w_func3;
    logic          w_size_b;
    logic          w_size_h;
    logic          w_size_w;
    logic          w_f3_ok;
    logic          w_misalign;
    logic          w_oor;
    logic          w_err;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_word;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_load;
    logic [3:0]    w_be;
    logic [31:0]   w_wlane;

    assign req_ready  = (r_state == S_IDLE) && !rst;
    assign resp_valid = (r_state == S_RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;
    assign w_accept   = req_valid && req_ready;

    // With LATENCY=1 RESP is entered on the accept edge, so decode straight from the request.
    assign w_we    = (r_state == S_IDLE) ? req_we    : r_we;
    assign w_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
    assign w_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;
    assign w_func3 = (r_state == S_IDLE) ? req_func3 : r_func3;

    assign w_enter_resp = (LAT1 && (r_state == S_IDLE) && w_accept)
                       || ((r_state == S_WAIT) && (r_count == CW'(1)));

    always_comb begin
        w_size_b   = (w_func3[1:0] == 2'b00);
        w_size_h   = (w_func3[1:0] == 2'b01);
        w_size_w   = (w_func3[1:0] == 2'b10);
        w_f3_ok    = (w_func3[1:0] != 2'b11) && !(w_func3[2] && (w_we || w_func3[1]));
        w_misalign = (w_size_h && w_addr[0]) || (w_size_w && (w_addr[1:0] != 2'b00));
        w_oor      = (w_addr[31:2] >= 30'(DEPTH_WORDS));
        w_err      = !w_f3_ok || w_misalign || w_oor;
        w_idx      = w_addr[AW+1:2];
        w_word     = r_mem[w_idx];
        w_byte     = w_word[{w_addr[1:0], 3'b000} +: 8];
        w_half     = w_word[{w_addr[1], 4'b0000} +: 16];
        case (w_func3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b010:  w_load = w_word;
            3'b100:  w_load = {24'd0, w_byte};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = 32'd0;
        endcase
        if (w_size_b) begin
            w_be    = 4'b0001 << w_addr[1:0];
            w_wlane = {4{w_wdata[7:0]}};
        end else if (w_size_h) begin
            w_be    = w_addr[1] ? 4'b1100 : 4'b0011;
            w_wlane = {2{w_wdata[15:0]}};
        end else begin
            w_be    = 4'b1111;
            w_wlane = w_wdata;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = LAT1 ? S_RESP : S_WAIT;
            S_WAIT: if (r_count == CW'(1)) w_next = S_RESP;
            S_RESP: if (resp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_func3 <= 3'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_we    <= req_we;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_func3 <= req_func3;
                r_count <= CW'(LATENCY - 1);
            end else if (r_state == S_WAIT) begin
                r_count <= r_count - CW'(1);
            end
            if (w_enter_resp) begin
                r_rdata <= (w_we || w_err) ? 32'd0 : w_load;
                r_err   <= w_err;
            end
        end
    end

    // RAM contents survive reset; a store commits only on the edge that enters RESP.
    always_ff @(posedge clk) begin
        if (w_enter_resp && w_we && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wlane[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - scoreboard bench for data_mem_responder
module tb_data_mem_responder;
    localparam int DEPTH = 256;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [2:0]  req_func3 = 3'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_func3(req_func3),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [2:0]  f3;
        logic [31:0] er;
        logic        ee;
    } op_t;

    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          acc_cyc;
    int          lat_seen;
    bit          got_ok;
    logic [31:0] got_rdata;
    logic        got_err;
    exp_t        sb[$];
    bit [31:0]   mdl [DEPTH];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic op_t op(logic we, logic [31:0] a, logic [31:0] wd, logic [2:0] f3,
                               logic [31:0] er, logic ee);
        op_t o;
        o.we = we; o.addr = a; o.wd = wd; o.f3 = f3; o.er = er; o.ee = ee;
        return o;
    endfunction

    // Reference memory: byte lanes written one at a time, loads rebuilt from the word.
    function automatic exp_t model_op(logic we, logic [31:0] a, logic [31:0] wd, logic [2:0] f3);
        exp_t      e;
        bit [31:0] w;
        int        size;
        int        sh;
        bit        bad;
        bad = 1'b0;
        size = 4;
        case (f3)
            3'b000, 3'b100: size = 1;
            3'b001, 3'b101: size = 2;
            3'b010:         size = 4;
            default:        bad = 1'b1;
        endcase
        if (we && f3[2]) bad = 1'b1;
        if (size == 2 && a[0]) bad = 1'b1;
        if (size == 4 && a[1:0] != 2'b00) bad = 1'b1;
        if (a >= 32'(4 * DEPTH)) bad = 1'b1;
        e.rdata = 32'd0;
        e.err = bad;
        if (!bad) begin
            w = mdl[a[31:2]];
            sh = 8 * int'(a[1:0]);
            if (we) begin
                for (int k = 0; k < size; k++) w[sh + 8*k +: 8] = wd[8*k +: 8];
                mdl[a[31:2]] = w;
            end else begin
                case (f3)
                    3'b000: e.rdata = {{24{w[sh+7]}}, w[sh +: 8]};
                    3'b100: e.rdata = {24'd0, w[sh +: 8]};
                    3'b001: e.rdata = {{16{w[sh+15]}}, w[sh +: 16]};
                    3'b101: e.rdata = {16'd0, w[sh +: 16]};
                    default: e.rdata = w;
                endcase
            end
        end
        return e;
    endfunction

    task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [2:0] f3);
        int w;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_func3 = f3;
        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) begin
            n_vec++;
            n_bad++;
            $display("FAIL accept_timeout req_ready=%0b required 1", req_ready);
        end
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        req_valid = 1'b0; req_we = ~we; req_addr = 32'hFFFF_FFFC;
        req_wdata = 32'h0BAD_0BAD; req_func3 = 3'b111;
    endtask

    task automatic collect();
        lat_seen = 1;
        while (!resp_valid && lat_seen < 20) begin
            @(posedge clk);
            #1;
            lat_seen++;
        end
        got_ok = resp_valid;
        got_rdata = resp_rdata;
        got_err = resp_err;
        if (resp_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic exec(input op_t o);
        sb.push_back('{rdata: o.er, err: o.ee});
        issue(o.we, o.addr, o.wd, o.f3);
        collect();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL rst_req_ready got=%b exp=0", req_ready); end
        n_vec++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_resp_valid got=%b exp=0", resp_valid); end
        n_vec++; if (resp_rdata !== 32'd0) begin n_bad++; $display("FAIL rst_rdata got=%h exp=0", resp_rdata); end
        n_vec++; if (resp_err !== 1'b0) begin n_bad++; $display("FAIL rst_err got=%b exp=0", resp_err); end
        rst = 1'b0;
        @(negedge clk);
        n_vec++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL idle_req_ready got=%b exp=1", req_ready); end
    endtask

    task automatic test_ops(input string name, input op_t ops[$]);
        exp_t e;
        foreach (ops[i]) begin
            exec(ops[i]);
            e = sb.pop_front();
            n_vec++;
            if (!got_ok || got_rdata !== e.rdata || got_err !== e.err || lat_seen != LAT) begin
                n_bad++;
                $display("FAIL %s_%0d valid=%b rdata=%h err=%b lat=%0d required rdata=%h err=%b lat=%0d",
                         name, i, got_ok, got_rdata, got_err, lat_seen, e.rdata, e.err, LAT);
            end
        end
    endtask

    task automatic test_word();
        op_t ops[$];
        ops.push_back(op(1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0, 0));
        ops.push_back(op(0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 0));
        test_ops("word", ops);
    endtask

    task automatic test_byte();
        op_t ops[$];
        ops.push_back(op(1, 32'h13, 32'h80, 3'b000, 32'h0, 0));
        ops.push_back(op(0, 32'h13, 32'h0, 3'b000, 32'hFFFFFF80, 0));
        ops.push_back(op(0, 32'h13, 32'h0, 3'b100, 32'h00000080, 0));
        ops.push_back(op(0, 32'h10, 32'h0, 3'b010, 32'h80ADBEEF, 0));
        test_ops("byte", ops);
    endtask

    task automatic test_half();
        op_t ops[$];
        ops.push_back(op(1, 32'h14, 32'hCAFEF00D, 3'b010, 32'h0, 0));
        ops.push_back(op(1, 32'h12, 32'h1234, 3'b001, 32'h0, 0));
        ops.push_back(op(0, 32'h12, 32'h0, 3'b101, 32'h00001234, 0));
        ops.push_back(op(0, 32'h11, 32'h0, 3'b001, 32'h0, 1));
        ops.push_back(op(1, 32'h16, 32'h99999999, 3'b010, 32'h0, 1));
        ops.push_back(op(0, 32'h14, 32'h0, 3'b010, 32'hCAFEF00D, 0));
        ops.push_back(op(0, 32'h10, 32'h0, 3'b010, 32'h1234BEEF, 0));
        ops.push_back(op(0, 32'h10, 32'h0, 3'b000, 32'hFFFFFFEF, 0));
        ops.push_back(op(0, 32'h10, 32'h0, 3'b001, 32'hFFFFBEEF, 0));
        test_ops("half", ops);
    endtask

    task automatic test_errors();
        op_t ops[$];
        ops.push_back(op(0, 32'h400, 32'h0, 3'b010, 32'h0, 1));
        ops.push_back(op(1, 32'h400, 32'h77, 3'b000, 32'h0, 1));
        ops.push_back(op(0, 32'h10, 32'h0, 3'b011, 32'h0, 1));
        ops.push_back(op(1, 32'h10, 32'h55, 3'b100, 32'h0, 1));
        ops.push_back(op(0, 32'h12, 32'h0, 3'b010, 32'h0, 1));
        ops.push_back(op(0, 32'hFFFFFFF0, 32'h0, 3'b010, 32'h0, 1));
        ops.push_back(op(0, 32'h10, 32'h0, 3'b010, 32'h1234BEEF, 0));
        ops.push_back(op(1, 32'h3FC, 32'hA5A5A5A5, 3'b010, 32'h0, 0));
        ops.push_back(op(0, 32'h3FF, 32'h0, 3'b100, 32'h000000A5, 0));
        test_ops("err", ops);
    endtask

    task automatic test_backpressure();
        exp_t        e;
        logic [31:0] hold_rdata;
        logic        hold_err;
        resp_ready = 1'b0;
        exec(op(0, 32'h14, 32'h0, 3'b010, 32'hCAFEF00D, 0));
        e = sb.pop_front();
        hold_rdata = resp_rdata;
        hold_err = resp_err;
        n_vec++;
        if (!got_ok || got_rdata !== e.rdata || got_err !== e.err) begin
            n_bad++;
            $display("FAIL bp_data rdata=%h err=%b required %h %b", got_rdata, got_err, e.rdata, e.err);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            n_vec++;
            if (resp_valid !== 1'b1 || resp_rdata !== hold_rdata || resp_err !== hold_err || req_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL bp_hold_%0d valid=%b rdata=%h err=%b req_ready=%b required 1 %h %b 0",
                         i, resp_valid, resp_rdata, resp_err, req_ready, hold_rdata, hold_err);
            end
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_release valid=%b req_ready=%b required 0 1", resp_valid, req_ready);
        end
    endtask

    task automatic test_back_to_back();
        op_t  ops[4];
        exp_t e;
        int   prev;
        ops[0] = op(1, 32'h30, 32'h01020304, 3'b010, 32'h0, 0);
        ops[1] = op(0, 32'h31, 32'h0, 3'b000, 32'h00000003, 0);
        ops[2] = op(0, 32'h32, 32'h0, 3'b001, 32'h00000102, 0);
        ops[3] = op(0, 32'h30, 32'h0, 3'b010, 32'h01020304, 0);
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            exec(ops[i]);
            e = sb.pop_front();
            n_vec++;
            if (!got_ok || got_rdata !== e.rdata || got_err !== e.err) begin
                n_bad++;
                $display("FAIL b2b_%0d rdata=%h err=%b required %h %b", i, got_rdata, got_err, e.rdata, e.err);
            end
            if (i > 0) begin
                n_vec++;
                if (acc_cyc - prev != LAT + 1) begin
                    n_bad++;
                    $display("FAIL b2b_spacing_%0d got=%0d required=%0d", i, acc_cyc - prev, LAT + 1);
                end
            end
            prev = acc_cyc;
        end
    endtask

    task automatic test_reset_mid();
        op_t ops[$];
        int  seen;
        test_ops("rm_pre", '{op(1, 32'h20, 32'h11, 3'b010, 32'h0, 0)});
        issue(1, 32'h20, 32'h55, 3'b010);
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL rm_async valid=%b req_ready=%b required 0 0", resp_valid, req_ready);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid !== 1'b0) seen++;
        end
        n_vec++;
        if (seen != 0 || req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rm_no_resp valid_cycles=%0d req_ready=%b required 0 1", seen, req_ready);
        end
        ops.push_back(op(0, 32'h20, 32'h0, 3'b010, 32'h11, 0));
        ops.push_back(op(0, 32'h10, 32'h0, 3'b010, 32'h1234BEEF, 0));
        ops.push_back(op(1, 32'h20, 32'h0, 3'b010, 32'h0, 0));
        ops.push_back(op(0, 32'h20, 32'h0, 3'b010, 32'h0, 0));
        test_ops("rm_post", ops);
        resp_ready = 1'b0;
        issue(0, 32'h14, 32'h0, 3'b010);
        collect();
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if (resp_valid !== 1'b0 || resp_rdata !== 32'd0 || resp_err !== 1'b0) begin
            n_bad++;
            $display("FAIL rm_resp_abort valid=%b rdata=%h err=%b required 0 0 0", resp_valid, resp_rdata, resp_err);
        end
        @(negedge clk);
        rst = 1'b0;
        resp_ready = 1'b1;
    endtask

    task automatic test_random();
        op_t         ops[$];
        logic        we;
        logic [31:0] a;
        logic [31:0] wd;
        logic [2:0]  f3;
        exp_t        e;
        for (int i = 0; i < 16; i++) begin
            wd = $urandom;
            e = model_op(1, 32'h100 + 32'(4*i), wd, 3'b010);
            ops.push_back(op(1, 32'h100 + 32'(4*i), wd, 3'b010, e.rdata, e.err));
        end
        for (int i = 0; i < 48; i++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a = ($urandom_range(0, 7) == 0) ? 32'h400 + 32'($urandom_range(0, 15))
                                            : 32'h100 + 32'($urandom_range(0, 63));
            wd = $urandom;
            e = model_op(we, a, wd, f3);
            ops.push_back(op(we, a, wd, f3, e.rdata, e.err));
        end
        test_ops("rand", ops);
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time=%0t limit=500000", $time);
        $fatal(1, "watchdog");
    end
endmodule
